// File: rtl/muldiv_iter_if.sv
`default_nettype none
// muldiv_iter_if: request/response bundle between the execute stage and the
// iterative multiply/divide unit.
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, funct3, a, b, flush, input busy, done, result);
    modport slave  (input start, funct3, a, b, flush, output busy, done, result);
endinterface
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// muldiv_iter: fixed-latency (WIDTH+2) RV32M multiply/divide unit using
// shift-add multiply and restoring divide on operand magnitudes.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_iter_if.slave bus
);
    localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [1:0]    S_IDLE = 2'd0;
    localparam logic [1:0]    S_CALC = 2'd1;
    localparam logic [1:0]    S_FIX  = 2'd2;
    localparam logic [1:0]    S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic             b_zero_q, b_zero_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic               accept;
    logic               a_sgn, b_sgn, a_neg, b_neg;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, fix_val;

    assign accept = (state_q == S_IDLE) && bus.start && !bus.flush;

    // Unsigned-a ops: MULHU, DIVU, REMU. Signed-b ops: MUL, MULH, DIV, REM.
    assign a_sgn = !(bus.funct3 == 3'b011) && !(bus.funct3[2] && bus.funct3[0]);
    assign b_sgn = bus.funct3[2] ? !bus.funct3[0] : !bus.funct3[1];
    assign a_neg = a_sgn && bus.a[WIDTH-1];
    assign b_neg = b_sgn && bus.b[WIDTH-1];

    // hi: partial product / partial remainder; lo: multiplier / quotient bits
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op2_q} : '0);
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, op2_q};

    // Signed overflow (MIN / -1) falls out of the magnitude path unaided.
    assign prod     = {hi_q, lo_q};
    assign prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
    assign quot_fix = (a_neg_q ^ b_neg_q) ? -lo_q : lo_q;
    assign rem_fix  = a_neg_q ? -hi_q : hi_q;

    always_comb begin
        fix_val = '0;
        case (op_q)
            3'b000:                 fix_val = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_val = b_zero_q ? '1 : quot_fix;
            default:                fix_val = b_zero_q ? a_q : rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            a_q      <= '0;
            op2_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            b_zero_q <= b_zero_d;
            a_q      <= a_d;
            op2_q    <= op2_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_CALC;
            S_CALC: begin
                if (bus.flush)          state_d = S_IDLE;
                else if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX:   state_d = bus.flush ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        b_zero_d = b_zero_q;
        a_d      = a_q;
        op2_d    = op2_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        if (accept) begin
            cnt_d    = '0;
            op_d     = bus.funct3;
            a_neg_d  = a_neg;
            b_neg_d  = b_neg;
            b_zero_d = (bus.b == '0);
            a_d      = bus.a;
            op2_d    = b_neg ? -bus.b : bus.b;
            hi_d     = '0;
            lo_d     = a_neg ? -bus.a : bus.a;
        end else if (state_q == S_CALC) begin
            cnt_d = cnt_q + CW'(1);
            if (!op_q[2]) begin
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end else if (!div_diff[WIDTH+1]) begin
                hi_d = div_diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = div_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else if ((state_q == S_FIX) && !bus.flush) begin
            result_d = fix_val;
        end
    end

    always_comb begin
        bus.busy = (state_q != S_IDLE);
        bus.done = (state_q == S_DONE);
    end

    assign bus.result = result_q;
endmodule
`default_nettype wire
